// File: rtl/comb_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module  : comb_sweep_pkg
// Purpose : Shared types and constants for the combinational sweep checker.
//           - sweep_state_t : sweep controller states
//           - MODE_BIN / MODE_GRAY : values of the seq_mode input
// Revision: 1.0 - initial release
// ============================================================================
package comb_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/comb_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module  : comb_sweep_gen
// Purpose : Stimulus generator for the sweep checker. Holds the vector index,
//           the per-vector settle counter and the registered stimulus vector
//           (binary or Gray encoding of the index).
// Ports   : clk, rst_n      - clock, async active-low reset
//           clear           - accepted start: zero index, latch mode
//           mode            - seq_mode to latch on clear
//           hold            - controller is in the settle phase
//           advance         - step to the next vector
//           vec_out         - registered stimulus vector
//           sample_stb      - settle phase complete, sample next cycle
//           last_vec        - index is all-ones
// Revision: 1.0 - initial release
// ============================================================================
module comb_sweep_gen
  import comb_sweep_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            mode,
  input  logic            hold,
  input  logic            advance,
  output logic [IN_W-1:0] vec_out,
  output logic            sample_stb,
  output logic            last_vec
);

  localparam logic [IN_W-1:0] c_one = IN_W'(1);

  logic [IN_W-1:0] r_idx;
  logic [IN_W-1:0] r_vec;
  logic            r_mode;
  logic [IN_W-1:0] w_idx_inc;
  logic [IN_W-1:0] w_vec_next;

  assign w_idx_inc  = r_idx + c_one;
  // Vector register is loaded with the encoding of the *next* index so that
  // vec_out changes in the same cycle as the index.
  assign w_vec_next = (r_mode == MODE_GRAY) ? (w_idx_inc ^ (w_idx_inc >> 1)) : w_idx_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_vec  <= '0;
      r_mode <= MODE_BIN;
    end else if (clear) begin
      r_idx  <= '0;
      r_vec  <= '0;
      r_mode <= mode;
    end else if (advance) begin
      r_idx  <= w_idx_inc;
      r_vec  <= w_vec_next;
    end
  end

  assign vec_out  = r_vec;
  assign last_vec = &r_idx;

  generate
    if (SETTLE == 0) begin : g_no_settle
      logic w_unused_hold;
      assign w_unused_hold = hold;
      assign sample_stb    = 1'b1;
    end else begin : g_settle
      localparam int c_cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;
      localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE - 1);
      localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

      logic [c_cnt_w-1:0] r_cnt;

      // Counts HOLD cycles of the current vector; self-clears on the strobe
      // so it is zero again when the next vector's HOLD phase begins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (hold && !sample_stb) begin
          r_cnt <= r_cnt + c_cnt_one;
        end else begin
          r_cnt <= '0;
        end
      end

      assign sample_stb = hold && (r_cnt == c_cnt_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/comb_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module  : comb_sweep_checker
// Purpose : Drives every IN_W-bit vector once to N_IMPL implementations of a
//           function, compares each against implementation 0, counts
//           mismatching vectors and reports pass/fail.
// Ports   : clk, rst_n            - clock, async active-low reset
//           start, seq_mode       - run request, binary/Gray order select
//           vec_out, impl_y       - stimulus out, implementation outputs in
//           busy, done, pass      - status
//           err_count             - saturating mismatching-vector count
//           first_err_valid/vec   - first mismatching vector
//           mismatch_mask         - sticky per-implementation mismatch flags
// Revision: 1.0 - initial release
// ============================================================================
module comb_sweep_checker
  import comb_sweep_pkg::*;
#(
  parameter int IN_W      = 4,
  parameter int N_IMPL    = 4,
  parameter int SETTLE    = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 seq_mode,
  output logic [IN_W-1:0]      vec_out,
  input  logic [N_IMPL-1:0]    impl_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [IN_W-1:0]      first_err_vec,
  output logic [N_IMPL-1:0]    mismatch_mask
);

  // State entered at the start of each vector; with no settle cycles the
  // HOLD phase is skipped entirely.
  localparam sweep_state_t c_vec_state = (SETTLE == 0) ? SAMPLE : HOLD;
  localparam logic [ERR_CNT_W-1:0] c_err_one = ERR_CNT_W'(1);

  sweep_state_t r_state;
  sweep_state_t w_state_next;

  logic w_start_acc;
  logic w_sample;
  logic w_advance;
  logic w_sample_stb;
  logic w_last_vec;

  logic [N_IMPL-1:0]    w_mism;
  logic                 w_any_mism;
  logic [ERR_CNT_W-1:0] r_err;
  logic                 r_first_valid;
  logic [IN_W-1:0]      r_first_vec;
  logic [N_IMPL-1:0]    r_mask;
  logic                 r_pass;

  comb_sweep_gen #(
    .IN_W   (IN_W),
    .SETTLE (SETTLE)
  ) u_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_start_acc),
    .mode       (seq_mode),
    .hold       (r_state == HOLD),
    .advance    (w_advance),
    .vec_out    (vec_out),
    .sample_stb (w_sample_stb),
    .last_vec   (w_last_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_sample     = 1'b0;
    w_advance    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = c_vec_state;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (w_sample_stb) begin
          w_state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        busy     = 1'b1;
        w_sample = 1'b1;
        if (w_last_vec) begin
          w_state_next = DONE;
        end else begin
          w_advance    = 1'b1;
          w_state_next = c_vec_state;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Bit 0 compares the golden output against itself and is therefore 0.
  assign w_mism     = impl_y ^ {N_IMPL{impl_y[0]}};
  assign w_any_mism = |w_mism;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err         <= '0;
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
      r_mask        <= '0;
      r_pass        <= 1'b0;
    end else if (w_start_acc) begin
      r_err         <= '0;
      r_first_valid <= 1'b0;
      r_first_vec   <= '0;
      r_mask        <= '0;
      r_pass        <= 1'b0;
    end else if (w_sample) begin
      r_mask <= r_mask | w_mism;
      if (w_any_mism) begin
        if (!(&r_err)) begin
          r_err <= r_err + c_err_one;
        end
        if (!r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_vec   <= vec_out;
        end
      end
      // Resolve pass on the last sample so it is already valid while done
      // is asserted.
      if (w_last_vec) begin
        r_pass <= (r_err == '0) && !w_any_mism;
      end
    end
  end

  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_valid = r_first_valid;
  assign first_err_vec   = r_first_vec;
  assign mismatch_mask   = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_comb_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_comb_sweep_checker
// Purpose : Self-checking bench for comb_sweep_checker. A main instance
//           (defaults) is exercised from a vector table plus reset and
//           held-start sequences; a second instance with a 3-bit error
//           counter covers saturation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_comb_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic       start = 1'b0;
  logic       seq_mode = 1'b0;
  logic [3:0] vec_out;
  logic [3:0] impl_y;
  logic       busy, done, pass, first_err_valid;
  logic [7:0] err_count;
  logic [3:0] first_err_vec, mismatch_mask;

  // saturation instance
  logic       start_s = 1'b0;
  logic [3:0] vec_s, impl_s, fev_s, mask_s;
  logic       busy_s, done_s, pass_s, fv_s;
  logic [2:0] err_s;

  // error injection for the main instance
  logic [3:0] inj_vec  = 4'h0;
  logic [3:0] inj_bits = 4'h0;
  logic       inj_all  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] rec [64];
  logic [3:0] gray_exp [16];

  typedef struct {
    logic       mode;
    logic [3:0] ivec;
    logic [3:0] ibits;
    logic       iall;
    logic [7:0] exp_err;
    logic       exp_fv;
    logic [3:0] exp_fvec;
    logic [3:0] exp_mask;
    logic       exp_pass;
  } vec_t;

  vec_t tbl [6];

  function automatic logic base_fn(input logic [3:0] v);
    return (^v) ^ (v[1] & v[3]);
  endfunction

  always_comb begin
    impl_y = {4{base_fn(vec_out)}};
    if (inj_all || (vec_out == inj_vec)) impl_y = impl_y ^ inj_bits;
  end

  always_comb impl_s = {4{base_fn(vec_s)}} ^ 4'b0010;

  comb_sweep_checker #(
    .IN_W(4), .N_IMPL(4), .SETTLE(1), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_mode(seq_mode),
    .vec_out(vec_out), .impl_y(impl_y), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_vec(first_err_vec), .mismatch_mask(mismatch_mask)
  );

  comb_sweep_checker #(
    .IN_W(4), .N_IMPL(4), .SETTLE(1), .ERR_CNT_W(3)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .seq_mode(1'b0),
    .vec_out(vec_s), .impl_y(impl_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .err_count(err_s), .first_err_valid(fv_s),
    .first_err_vec(fev_s), .mismatch_mask(mask_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start in IDLE, then record vec_out on every busy cycle until done.
  task automatic run_sweep(input logic mode, output int nbusy);
    int guard;
    @(negedge clk);
    seq_mode = mode;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    seq_mode = ~mode;   // must have been latched already
    nbusy = 0;
    guard = 0;
    while (!done && guard < 200) begin
      if (busy) begin
        if (nbusy < 64) rec[nbusy] = vec_out;
        nbusy++;
      end
      guard++;
      @(negedge clk);
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int         nbusy;
    int         bad_idx;
    int         guard;
    int         cyc;
    int         ndone;
    int         done_at [3];
    logic [3:0] exp_v;
    logic [7:0] err_snap;
    logic       pass_snap;

    gray_exp = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    //          mode  ivec   ibits    iall  err    fv    fvec   mask     pass
    tbl[0] = '{1'b0, 4'h0, 4'b0000, 1'b0, 8'd0,  1'b0, 4'h0, 4'b0000, 1'b1};
    tbl[1] = '{1'b0, 4'hA, 4'b0100, 1'b0, 8'd1,  1'b1, 4'hA, 4'b0100, 1'b0};
    tbl[2] = '{1'b1, 4'hA, 4'b0100, 1'b0, 8'd1,  1'b1, 4'hA, 4'b0100, 1'b0};
    tbl[3] = '{1'b0, 4'h0, 4'b0010, 1'b1, 8'd16, 1'b1, 4'h0, 4'b0010, 1'b0};
    tbl[4] = '{1'b1, 4'h3, 4'b1010, 1'b0, 8'd1,  1'b1, 4'h3, 4'b1010, 1'b0};
    tbl[5] = '{1'b0, 4'h7, 4'b0001, 1'b0, 8'd1,  1'b1, 4'h7, 4'b1110, 1'b0};

    // reset state
    #12;
    check("reset_state",
          {14'd0, busy, done, pass, first_err_valid, err_count, first_err_vec, mismatch_mask, vec_out},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven sweeps
    for (int t = 0; t < 6; t++) begin
      inj_vec  = tbl[t].ivec;
      inj_bits = tbl[t].ibits;
      inj_all  = tbl[t].iall;
      run_sweep(tbl[t].mode, nbusy);
      check($sformatf("t%0d_busy_cycles", t), nbusy, 32'd32);
      check($sformatf("t%0d_busy_in_done", t), {31'd0, busy}, 32'd0);
      check($sformatf("t%0d_err_count", t), {24'd0, err_count}, {24'd0, tbl[t].exp_err});
      check($sformatf("t%0d_first_err_valid", t), {31'd0, first_err_valid}, {31'd0, tbl[t].exp_fv});
      check($sformatf("t%0d_first_err_vec", t), {28'd0, first_err_vec}, {28'd0, tbl[t].exp_fvec});
      check($sformatf("t%0d_mismatch_mask", t), {28'd0, mismatch_mask}, {28'd0, tbl[t].exp_mask});
      check($sformatf("t%0d_pass", t), {31'd0, pass}, {31'd0, tbl[t].exp_pass});
      // each vector held two cycles, in the selected order
      bad_idx = -1;
      for (int k = 0; k < 16; k++) begin
        exp_v = tbl[t].mode ? gray_exp[k] : 4'(k);
        if (bad_idx < 0 && (rec[2*k] !== exp_v || rec[2*k+1] !== exp_v)) bad_idx = k;
      end
      check($sformatf("t%0d_vec_order_bad_idx", t), bad_idx, 32'hFFFF_FFFF);
      // results hold after done
      err_snap  = err_count;
      pass_snap = pass;
      repeat (3) @(negedge clk);
      check($sformatf("t%0d_done_one_cycle", t), {30'd0, done, busy}, 32'd0);
      check($sformatf("t%0d_hold_err", t), {24'd0, err_count}, {24'd0, tbl[t].exp_err});
      check($sformatf("t%0d_hold_pass", t), {31'd0, pass}, {31'd0, tbl[t].exp_pass});
    end

    // Gray order: every step changes exactly one bit
    bad_idx = -1;
    run_sweep(1'b1, nbusy);
    for (int k = 1; k < 16; k++) begin
      if (bad_idx < 0 && $countones(rec[2*k] ^ rec[2*k-2]) != 1) bad_idx = k;
    end
    check("gray_single_bit_steps", bad_idx, 32'hFFFF_FFFF);

    // asynchronous reset mid-sweep at vec_out == 5
    inj_all  = 1'b0;
    inj_vec  = 4'h2;
    inj_bits = 4'b0100;
    @(negedge clk);
    seq_mode = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (vec_out != 4'h5 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("reached_vec5", {28'd0, vec_out}, 32'd5);
    check("err_before_reset", {24'd0, err_count}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {14'd0, busy, done, pass, first_err_valid, err_count, first_err_vec, mismatch_mask, vec_out},
          32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    inj_bits = 4'b0000;
    run_sweep(1'b0, nbusy);
    check("post_reset_busy_cycles", nbusy, 32'd32);
    check("post_reset_pass", {31'd0, pass}, 32'd1);
    bad_idx = -1;
    for (int k = 0; k < 16; k++) begin
      if (bad_idx < 0 && (rec[2*k] !== 4'(k))) bad_idx = k;
    end
    check("post_reset_order_bad_idx", bad_idx, 32'hFFFF_FFFF);

    // saturating counter (3-bit) with impl 1 always inverted
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    nbusy = 0;
    guard = 0;
    while (!done_s && guard < 200) begin
      if (busy_s) nbusy++;
      guard++;
      @(negedge clk);
    end
    check("sat_done_seen", {31'd0, done_s}, 32'd1);
    check("sat_busy_cycles", nbusy, 32'd32);
    check("sat_err_count", {29'd0, err_s}, 32'd7);
    check("sat_first_err_vec", {28'd0, fev_s}, 32'd0);
    check("sat_first_err_valid", {31'd0, fv_s}, 32'd1);
    check("sat_mask", {28'd0, mask_s}, 32'b0010);
    check("sat_pass", {31'd0, pass_s}, 32'd0);

    // start held high: back-to-back sweeps, one done per sweep
    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_at[ndone] = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    check("held_start_done_count", ndone, 32'd3);
    if (ndone == 3) begin
      check("held_start_period_1", done_at[1] - done_at[0], 32'd34);
      check("held_start_period_2", done_at[2] - done_at[1], 32'd34);
    end
    check("held_start_pass", {31'd0, pass}, 32'd1);
    repeat (3) @(negedge clk);
    check("held_start_released_idle", {30'd0, busy, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
